// File: rtl/touch_scan.sv
// Active pad scanner: drives one pad low at a time and senses the rest through their pull-ups.
// Produces a debounced N x N contact matrix, a per-pad stuck-low flag and per-scan pulses.
module touch_scan #(
  parameter int N_PADS     = 4,
  parameter int SETTLE_CYC = 48,
  parameter int GAP_CYC    = 48_000,
  parameter int DEBOUNCE   = 3
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [N_PADS-1:0]          i_pad_in,
  output logic [N_PADS-1:0]          o_pad_oe,
  output logic [N_PADS-1:0]          o_pad_out,
  output logic [N_PADS*N_PADS-1:0]   o_matrix,
  output logic [N_PADS-1:0]          o_stuck,
  output logic                       o_scan_done,
  output logic                       o_change
);

  localparam int CNT_MAX = (GAP_CYC > SETTLE_CYC) ? GAP_CYC : SETTLE_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int K_W     = $clog2(N_PADS);
  localparam int RUN_W   = $clog2(DEBOUNCE + 1);
  localparam int MAT_W   = N_PADS * N_PADS;

  localparam logic [CNT_W-1:0]  GAP_LAST    = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [K_W-1:0]    K_LAST      = K_W'(N_PADS - 1);
  localparam logic [RUN_W-1:0]  RUN_MAX     = RUN_W'(DEBOUNCE);
  localparam logic [N_PADS-1:0] PAD_ONE     = N_PADS'(1);

  typedef enum logic [1:0] {
    ST_GAP,
    ST_DRIVE,
    ST_SAMPLE,
    ST_COMMIT
  } state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [K_W-1:0]     k_reg, k_next;
  logic [N_PADS-1:0]  oe_reg, oe_next;
  logic               capture_stuck;
  logic               capture_row;

  logic [N_PADS-1:0]  pad_meta_reg;
  logic [N_PADS-1:0]  pad_sync_reg;
  logic [N_PADS-1:0]  stuck_raw_reg;
  logic [N_PADS-1:0]  stuck_reg;
  logic [N_PADS-1:0]  row_reg [N_PADS];
  logic [N_PADS-1:0]  k_onehot;
  logic [N_PADS-1:0]  row_value;
  logic [MAT_W-1:0]   matrix_cap;
  logic [MAT_W-1:0]   cand_reg;
  logic [MAT_W-1:0]   matrix_reg;
  logic [RUN_W-1:0]   run_reg;
  logic [RUN_W-1:0]   run_new;
  logic               commit_new;
  logic               done_reg;
  logic               change_reg;

  // Pads idle high through their pull-ups, so the synchronizer resets to all ones.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pad_meta_reg <= '1;
      pad_sync_reg <= '1;
    end else begin
      pad_meta_reg <= i_pad_in;
      pad_sync_reg <= pad_meta_reg;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= ST_GAP;
      cnt_reg   <= '0;
      k_reg     <= '0;
      oe_reg    <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      k_reg     <= k_next;
      oe_reg    <= oe_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    k_next        = k_reg;
    capture_stuck = 1'b0;
    capture_row   = 1'b0;
    case (state_reg)
      ST_GAP: begin
        if (cnt_reg == GAP_LAST) begin
          cnt_next      = '0;
          k_next        = '0;
          capture_stuck = 1'b1;
          state_next    = ST_DRIVE;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ST_DRIVE: begin
        if (cnt_reg == SETTLE_LAST) begin
          cnt_next   = '0;
          state_next = ST_SAMPLE;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ST_SAMPLE: begin
        capture_row = 1'b1;
        if (k_reg == K_LAST) begin
          state_next = ST_COMMIT;
        end else begin
          k_next     = k_reg + K_W'(1);
          state_next = ST_DRIVE;
        end
      end
      ST_COMMIT: begin
        state_next = ST_GAP;
      end
      default: begin
        state_next = ST_GAP;
      end
    endcase
    // Output enable is registered off the next state so the pad lines never glitch.
    if (state_next == ST_DRIVE || state_next == ST_SAMPLE) begin
      oe_next = PAD_ONE << k_next;
    end else begin
      oe_next = '0;
    end
  end

  // Stuck pads read low while nothing is driven; capture them just before the scan starts.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stuck_raw_reg <= '0;
    end else if (capture_stuck) begin
      stuck_raw_reg <= ~pad_sync_reg;
    end
  end

  assign k_onehot  = PAD_ONE << k_reg;
  assign row_value = ~pad_sync_reg & ~k_onehot;

  generate
    for (genvar gi = 0; gi < N_PADS; gi++) begin : g_row
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          row_reg[gi] <= '0;
        end else if (capture_row && k_onehot[gi]) begin
          row_reg[gi] <= row_value;
        end
      end
      assign matrix_cap[gi*N_PADS +: N_PADS] = row_reg[gi];
    end
  endgenerate

  // A new pattern restarts the run at 1; a repeated one counts up and saturates.
  always_comb begin
    if (matrix_cap != cand_reg) begin
      run_new = RUN_W'(1);
    end else if (run_reg == RUN_MAX) begin
      run_new = run_reg;
    end else begin
      run_new = run_reg + RUN_W'(1);
    end
    commit_new = (run_new == RUN_MAX) && (matrix_cap != matrix_reg);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cand_reg   <= '0;
      run_reg    <= '0;
      matrix_reg <= '0;
      stuck_reg  <= '0;
      done_reg   <= 1'b0;
      change_reg <= 1'b0;
    end else begin
      done_reg   <= (state_reg == ST_COMMIT);
      change_reg <= 1'b0;
      if (state_reg == ST_COMMIT) begin
        cand_reg  <= matrix_cap;
        run_reg   <= run_new;
        stuck_reg <= stuck_raw_reg;
        if (commit_new) begin
          matrix_reg <= matrix_cap;
          change_reg <= 1'b1;
        end
      end
    end
  end

  assign o_pad_oe    = oe_reg;
  assign o_pad_out   = '0;
  assign o_matrix    = matrix_reg;
  assign o_stuck     = stuck_reg;
  assign o_scan_done = done_reg;
  assign o_change    = change_reg;

endmodule
